// File: rtl/game_vga_render.sv
// rtl/game_vga_render.sv - 640x480@60 VGA renderer for the bird/pipe game state
//
// Purpose: generates VGA timing from a pixel strobe, snapshots the game state
// once per frame at the start of vertical blanking (so a frame never tears),
// and draws sky, pipes and bird through a 2-stage pixel pipeline.
// Optional feature macro: SCORE_BAR_EN (score bar in rows 0..7).
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   pix_en           pixel strobe; every register advances only when high
//   bird_y [15:0]    [9:0] bird bottom y, [15] 1 = rising
//   pipe1..3 [19:0]  [19:10] pipe left x, [9:0] lower-pipe top y
//   score [3:0]      current score (used only with SCORE_BAR_EN)
//   fail             game over
//   hsync, vsync     active-low sync, aligned with the colour outputs
//   vga_r/g/b [3:0]  colour, 0 during blanking
//   frame_start      one-clk pulse when the snapshot is taken
module game_vga_render #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int BIRD_X   = 100,
   parameter int BIRD_W   = 34,
   parameter int BIRD_H   = 24,
   parameter int PIPE_W   = 52,
   parameter int PIPE_GAP = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [15:0] bird_y,
   input  logic [19:0] pipe1,
   input  logic [19:0] pipe2,
   input  logic [19:0] pipe3,
   input  logic [3:0]  score,
   input  logic        fail,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] BX_LO     = 11'(BIRD_X);
   localparam logic [10:0] BX_HI     = 11'(BIRD_X + BIRD_W);
   localparam logic [10:0] BH_M1     = 11'(BIRD_H - 1);
   localparam logic [10:0] PW11      = 11'(PIPE_W);
   localparam logic [10:0] GAP11     = 11'(PIPE_GAP);

   // S0: position counters
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;

   // frame snapshot of the game state
   logic [9:0]       by_q;
   logic             rise_q;
   logic             fail_q;
   logic [2:0][9:0]  px_q;
   logic [2:0][9:0]  py_q;
   logic [2:0][19:0] pipe_in;

   // S1: hit flags and sync for the pixel seen in S0
   logic s1_valid_q, s1_active_q, s1_hs_q, s1_vs_q;
   logic s1_bird_q, s1_pipe_q, s1_bar_q;

   // S2: output registers
   logic [11:0] rgb_q, rgb_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        frame_start_q;

   logic        snap_take;
   logic        active0, hs0, vs0, bird_hit, pipe_hit, bar_hit;
   logic [10:0] h11, v11;

   assign pipe_in   = {pipe3, pipe2, pipe1};
   assign snap_take = pix_en && (hcnt_q == 10'd0) && (vcnt_q == V_ACT);
   assign h11       = {1'b0, hcnt_q};
   assign v11       = {1'b0, vcnt_q};

   always_comb begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = 10'd0;
         vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end
   end

   assign active0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign hs0     = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
   assign vs0     = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));

   // Bird spans rows [by-BIRD_H+1, by]; adding BIRD_H-1 to vcnt instead of
   // subtracting from by keeps the lower bound clamped at row 0.
   assign bird_hit = (h11 >= BX_LO) && (h11 < BX_HI) &&
                     (v11 + BH_M1 >= {1'b0, by_q}) && (v11 <= {1'b0, by_q});

   // Upper segment only exists when the opening fits above the lower pipe.
   always_comb begin
      pipe_hit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if ((h11 >= {1'b0, px_q[k]}) && (h11 < {1'b0, px_q[k]} + PW11) &&
             ((v11 >= {1'b0, py_q[k]}) ||
              (({1'b0, py_q[k]} >= GAP11) && (v11 < {1'b0, py_q[k]} - GAP11))))
            pipe_hit = 1'b1;
      end
   end

`ifdef SCORE_BAR_EN
   logic [3:0] score_q;
   logic       unused_bits;
   assign unused_bits = ^bird_y[14:10];
   assign bar_hit = (vcnt_q < 10'd8) && (hcnt_q >= 10'd8) &&
                    (h11 < 11'd8 + {3'b000, score_q, 4'b0000});
`else
   logic       unused_bits;
   assign unused_bits = ^{bird_y[14:10], score};
   assign bar_hit = 1'b0;
`endif

   // Snapshot registers are stable for the whole time S2 shows active pixels,
   // so reading fail/rise here instead of carrying them through S1 is safe.
   always_comb begin
      rgb_d = 12'h000;
      if (s1_valid_q && s1_active_q) begin
         if (s1_bird_q)      rgb_d = rise_q ? 12'hF80 : 12'hFF0;
         else if (s1_bar_q)  rgb_d = 12'hFFF;
         else if (s1_pipe_q) rgb_d = 12'h0A0;
         else                rgb_d = fail_q ? 12'h800 : 12'h4CF;
      end
      hsync_d = s1_valid_q ? s1_hs_q : 1'b1;
      vsync_d = s1_valid_q ? s1_vs_q : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         by_q          <= '0;
         rise_q        <= 1'b0;
         fail_q        <= 1'b0;
         px_q          <= '0;
         py_q          <= '0;
`ifdef SCORE_BAR_EN
         score_q       <= '0;
`endif
         s1_valid_q    <= 1'b0;
         s1_active_q   <= 1'b0;
         s1_hs_q       <= 1'b1;
         s1_vs_q       <= 1'b1;
         s1_bird_q     <= 1'b0;
         s1_pipe_q     <= 1'b0;
         s1_bar_q      <= 1'b0;
         rgb_q         <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= snap_take;
         if (snap_take) begin
            by_q   <= bird_y[9:0];
            rise_q <= bird_y[15];
            fail_q <= fail;
            for (int k = 0; k < 3; k++) begin
               px_q[k] <= pipe_in[k][19:10];
               py_q[k] <= pipe_in[k][9:0];
            end
`ifdef SCORE_BAR_EN
            score_q <= score;
`endif
         end
         if (pix_en) begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            s1_valid_q  <= 1'b1;
            s1_active_q <= active0;
            s1_hs_q     <= hs0;
            s1_vs_q     <= vs0;
            s1_bird_q   <= bird_hit;
            s1_pipe_q   <= pipe_hit;
            s1_bar_q    <= bar_hit;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_game_vga_render.sv
// tb/tb_game_vga_render.sv - scoreboard bench for game_vga_render on a reduced 80x48 raster
module tb_game_vga_render;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 40, VF = 2, VS = 2, VB = 4;
   localparam int HT = HA + HF + HS + HB;   // 80
   localparam int VT = VA + VF + VS + VB;   // 48
   localparam int FT = HT * VT;             // 3840

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic [15:0] bird_y;
   logic [19:0] pipe1, pipe2, pipe3;
   logic [3:0]  score;
   logic        fail;
   logic        hsync, vsync, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;

   game_vga_render #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BIRD_X(10), .BIRD_W(6), .BIRD_H(4), .PIPE_W(8), .PIPE_GAP(12)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .bird_y(bird_y),
      .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3), .score(score), .fail(fail),
      .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int div = 4;
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         pix_en = ((c % div) == 0);
         c++;
      end
   end

   int   tick = 0;
   logic rst_d = 1'b1;
   always @(posedge clk) begin
      rst_d <= rst;
      if (rst) tick <= 0;
      else if (pix_en) tick <= tick + 1;
   end

   typedef struct {
      int          pos;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       name;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   task automatic push_raw(input int pos, input logic [11:0] c, input logic h, input logic v,
                           input string nm);
      exp_t e;
      e.pos = pos; e.rgb = c; e.hs = h; e.vs = v; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic push_px(input int f, input int x, input int y, input logic [11:0] c,
                          input string nm);
      push_raw(f * FT + y * HT + x, c, !(x >= HA + HF && x < HA + HF + HS),
               !(y >= VA + VF && y < VA + VF + VS), nm);
   endtask

   // Monitor
   logic [11:0] mrgb;
   exp_t        he;
   int          last_tick = 0, pos, cf, last_cf = -1, fs_cnt = 0, ox, oy;
   logic        fs_prev = 1'b0, ehs, evs;
   logic [11:0] ergb;
   int          t_hs_err = 0, t_vs_err = 0, t_rgb_err = 0, t_hs_low = 0, t_vs_low = 0;

   always @(negedge clk) begin
      mrgb = {vga_r, vga_g, vga_b};
      if (rst_d) begin
         checks++;
         if (hsync !== 1'b1 || vsync !== 1'b1 || mrgb !== 12'h000 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got hs=%b vs=%b rgb=%h fs=%b need hs=1 vs=1 rgb=000 fs=0",
                     hsync, vsync, mrgb, frame_start);
         end
         while (sb_q.size() > 0) begin
            he = sb_q.pop_front();
            errors++;
            $display("FAIL %s never observed before reset", he.name);
         end
         last_tick = 0; fs_prev = 1'b0; fs_cnt = 0; last_cf = -1;
      end else begin
         if (frame_start) begin
            checks++;
            if (fs_prev || ((tick - 1) % FT) != VA * HT) begin
               errors++;
               $display("FAIL frame_start_pos got tick=%0d prev=%b need tick%%%0d=%0d width 1",
                        tick - 1, fs_prev, FT, VA * HT);
            end
            fs_cnt++;
         end
         fs_prev = frame_start;
         if (tick != last_tick) begin
            last_tick = tick;
            pos = tick - 2;
            cf = (tick - 1) / FT;
            if (cf != last_cf) begin
               if (last_cf >= 0) begin
                  checks++;
                  if (fs_cnt != 1) begin
                     errors++;
                     $display("FAIL frame_start_count frame %0d got %0d need 1", last_cf, fs_cnt);
                  end
               end
               fs_cnt = 0;
               last_cf = cf;
            end
            // frame 1: full-raster sync and sky sweep
            if (pos >= FT && pos < 2 * FT) begin
               ox = pos % HT;
               oy = (pos / HT) % VT;
               ehs = !(ox >= HA + HF && ox < HA + HF + HS);
               evs = !(oy >= VA + VF && oy < VA + VF + VS);
               ergb = (ox < HA && oy < VA) ? 12'h4CF : 12'h000;
               if (hsync !== ehs) t_hs_err++;
               if (vsync !== evs) t_vs_err++;
               if (mrgb !== ergb) t_rgb_err++;
               if (hsync === 1'b0) t_hs_low++;
               if (vsync === 1'b0) t_vs_low++;
               if (pos == 2 * FT - 1) begin
                  checks += 5;
                  if (t_hs_err != 0) begin errors++; $display("FAIL timing_hsync got %0d bad ticks need 0", t_hs_err); end
                  if (t_vs_err != 0) begin errors++; $display("FAIL timing_vsync got %0d bad ticks need 0", t_vs_err); end
                  if (t_rgb_err != 0) begin errors++; $display("FAIL timing_sky got %0d bad pixels need 0", t_rgb_err); end
                  if (t_hs_low != VT * HS) begin errors++; $display("FAIL hsync_low_total got %0d need %0d", t_hs_low, VT * HS); end
                  if (t_vs_low != VS * HT) begin errors++; $display("FAIL vsync_low_total got %0d need %0d", t_vs_low, VS * HT); end
               end
            end
            while (sb_q.size() > 0 && sb_q[0].pos < pos) begin
               he = sb_q.pop_front();
               errors++;
               $display("FAIL %s skipped", he.name);
            end
            if (sb_q.size() > 0 && sb_q[0].pos == pos) begin
               he = sb_q.pop_front();
               checks++;
               if (mrgb !== he.rgb || hsync !== he.hs || vsync !== he.vs) begin
                  errors++;
                  $display("FAIL %s got rgb=%h hs=%b vs=%b need rgb=%h hs=%b vs=%b",
                           he.name, mrgb, hsync, vsync, he.rgb, he.hs, he.vs);
               end
            end
         end
      end
   end

   task automatic wait_tick(input int n);
      int guard;
      guard = 0;
      while (tick < n && guard < 40000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (tick < n) begin
         checks++;
         errors++;
         $display("FAIL wait_tick got %0d need %0d", tick, n);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      bird_y = 16'd600;
      pipe1 = {10'd1000, 10'd0}; pipe2 = {10'd1000, 10'd0}; pipe3 = {10'd1000, 10'd0};
      score = 4'd0; fail = 1'b0;
      do_reset(4);

      // frame 0 renders the all-zero reset snapshot
      push_raw(-1, 12'h000, 1'b1, 1'b1, "first_tick_blank");
      push_px(0, 0, 0, 12'h0A0, "f0_pipe_0_0");
      push_px(0, 10, 0, 12'hFF0, "f0_bird_10_0");
      push_px(0, 15, 0, 12'hFF0, "f0_bird_15_0");
      push_px(0, 16, 0, 12'h4CF, "f0_sky_16_0");
      push_px(0, 10, 1, 12'h4CF, "f0_sky_10_1");
      push_px(0, 8, 5, 12'h4CF, "f0_sky_8_5");
      push_px(0, 7, 39, 12'h0A0, "f0_pipe_7_39");

      // render inputs, captured at the end of frame 1, shown in frame 2
      wait_tick(FT + 100);
      bird_y = 16'h0014;
      pipe1 = {10'd30, 10'd25};
      push_px(2, 30, 12, 12'h0A0, "f2_upper_30_12");
      push_px(2, 30, 13, 12'h4CF, "f2_gap_30_13");
      push_px(2, 10, 16, 12'h4CF, "f2_above_bird");
      push_px(2, 10, 17, 12'hFF0, "f2_bird_top");
      push_px(2, 15, 20, 12'hFF0, "f2_bird_bottom_right");
      push_px(2, 30, 25, 12'h0A0, "f2_lower_top");
      push_px(2, 38, 25, 12'h4CF, "f2_right_of_pipe");
      push_px(2, 20, 30, 12'h4CF, "f2_iso_new_x_hidden");
      push_px(2, 30, 30, 12'h0A0, "f2_iso_old_x_kept");
      push_px(2, 29, 39, 12'h4CF, "f2_left_of_pipe");
      push_px(2, 37, 39, 12'h0A0, "f2_lower_last");

      wait_tick(2 * FT);
      div = 2;

      // mid-frame change at line 20; visible only from frame 3
      wait_tick(2 * FT + 20 * HT + 5);
      bird_y = 16'h0002;
      pipe1 = {10'd20, 10'd25};
      pipe2 = {10'd40, 10'd5};
      pipe3 = {10'd60, 10'd0};
      push_px(3, 10, 0, 12'hFF0, "f3_bird_row0");
      push_px(3, 40, 0, 12'h4CF, "f3_small_y_no_upper_0");
      push_px(3, 15, 2, 12'hFF0, "f3_bird_row2");
      push_px(3, 10, 3, 12'h4CF, "f3_bird_below");
      push_px(3, 40, 4, 12'h4CF, "f3_small_y_no_upper_4");
      push_px(3, 27, 5, 12'h0A0, "f3_upper_right_edge");
      push_px(3, 28, 5, 12'h4CF, "f3_upper_past_edge");
      push_px(3, 40, 5, 12'h0A0, "f3_small_y_lower");
      push_px(3, 59, 10, 12'h4CF, "f3_clip_left");
      push_px(3, 60, 10, 12'h0A0, "f3_clip_first");
      push_px(3, 63, 10, 12'h0A0, "f3_clip_last");
      push_px(3, 64, 10, 12'h000, "f3_clip_blank");
      push_px(3, 20, 30, 12'h0A0, "f3_iso_new_x");
      push_px(3, 30, 30, 12'h4CF, "f3_iso_old_x_gone");
      push_px(3, 10, 39, 12'h4CF, "f3_bird_no_wrap");
      push_px(3, 47, 39, 12'h0A0, "f3_small_y_bottom");

      // fail with rising bird, shown in frame 4
      wait_tick(3 * FT + 100);
      fail = 1'b1;
      bird_y = 16'h8014;
      pipe1 = {10'd1000, 10'd0}; pipe2 = {10'd1000, 10'd0}; pipe3 = {10'd1000, 10'd0};
      push_px(4, 0, 0, 12'h800, "f4_fail_bg");
      push_px(4, 64, 0, 12'h000, "f4_blank");
      push_px(4, 10, 16, 12'h800, "f4_fail_bg_above_bird");
      push_px(4, 15, 17, 12'hF80, "f4_rising_top");
      push_px(4, 10, 20, 12'hF80, "f4_rising_bottom");
      push_px(4, 63, 29, 12'h800, "f4_fail_bg_last");

      // reset at (40,30) of frame 4
      wait_tick(4 * FT + 30 * HT + 40);
      do_reset(3);
      push_raw(-1, 12'h000, 1'b1, 1'b1, "post_reset_blank");
      push_px(0, 0, 0, 12'h0A0, "post_reset_pipe_0_0");
      push_px(0, 9, 0, 12'h4CF, "post_reset_sky");
      push_px(0, 10, 0, 12'hFF0, "post_reset_bird");
      push_px(0, 8, 1, 12'h4CF, "post_reset_sky_8_1");
      push_px(0, 7, 3, 12'h0A0, "post_reset_pipe_7_3");

      wait_tick(4 * HT);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending need 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
